// File: rtl/arbitro_rr_8a3.sv
// Round-robin arbiter for 8 requesters: one grant at a time, held until the owner
// releases (done, withdrawal or hold timeout), then priority rotates past the owner.
module arbitro_rr_8a3 #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic [7:0] grant_o,
    output logic [2:0] grant_idx_o,
    output logic       valid_o,
    output logic       timeout_o
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       grant_q, grant_d;
    logic [2:0]       idx_q, idx_d;
    logic             timeout_q, timeout_d;

    logic [2:0] pick;
    logic       rel_done, rel_wdraw, rel_tmo;

    // Scan from ptr upward; iterating downward lets the nearest candidate win last.
    always_comb begin
        pick = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            if (req_i[ptr_q + 3'(k)]) begin
                pick = ptr_q + 3'(k);
            end
        end
    end

    assign rel_done  = done_i;
    assign rel_wdraw = ~req_i[idx_q];
    assign rel_tmo   = (TIMEOUT != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en_i && (req_i != 8'h00)) begin
                    state_d = StGrant;
                    grant_d = 8'b1 << pick;
                    idx_d   = pick;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (rel_done || rel_wdraw || rel_tmo) begin
                    state_d   = StIdle;
                    grant_d   = 8'h00;
                    idx_d     = 3'd0;
                    ptr_d     = idx_q + 3'd1;
                    timeout_d = rel_tmo && !rel_done && !rel_wdraw;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ptr_q     <= 3'd0;
            cnt_q     <= '0;
            grant_q   <= 8'h00;
            idx_q     <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign valid_o     = (state_q == StGrant);
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_arbitro_rr_8a3.sv
// Bench for arbitro_rr_8a3: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the round-robin grant rules.
module tb_arbitro_rr_8a3;

    localparam int unsigned TO = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b0;
    logic [7:0] req_i = 8'h00;
    logic       done_i = 1'b0;
    logic [7:0] grant_o;
    logic [2:0] grant_idx_o;
    logic       valid_o;
    logic       timeout_o;

    int checks = 0;
    int failures = 0;

    // Model: who owns the resource, for how many cycles, and where the scan starts.
    bit m_busy;
    int m_owner;
    int m_held;
    int m_ptr;
    bit m_to;

    arbitro_rr_8a3 #(
        .TIMEOUT(TO),
        .CNT_W  (3)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .req_i      (req_i),
        .done_i     (done_i),
        .grant_o    (grant_o),
        .grant_idx_o(grant_idx_o),
        .valid_o    (valid_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_held  = 0;
        m_ptr   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step();
        bit a, b, c;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        m_to = 1'b0;
        if (!m_busy) begin
            if (en_i && req_i != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (req_i[(m_ptr + k) % 8]) begin
                        m_owner = (m_ptr + k) % 8;
                        break;
                    end
                end
                m_busy = 1'b1;
                m_held = 0;
            end
        end else begin
            a = done_i;
            b = !req_i[m_owner];
            c = (TO != 0) && (m_held + 1 == TO);
            if (a || b || c) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 8;
                m_to   = c && !a && !b;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".grant"}, 32'(grant_o), m_busy ? 32'(1) << m_owner : 32'd0);
        check_eq({tag, ".idx"}, 32'(grant_idx_o), m_busy ? 32'(m_owner) : 32'd0);
        check_eq({tag, ".valid"}, 32'(valid_o), 32'(m_busy));
        check_eq({tag, ".timeout"}, 32'(timeout_o), 32'(m_to));
    endtask

    // Inputs are set before calling; they stay stable across the rising edge.
    task automatic tick(input string tag);
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_i  = 8'($urandom);
        done_i = 1'($urandom);
        en_i   = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async");
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all("rst_held");
        rst_ni = 1'b1;
        en_i   = 1'b0;
        req_i  = 8'h00;
        done_i = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();

        // 1: reset, then no grant without both en and a request
        do_reset();
        en_i = 1'b0; req_i = 8'hA5; tick("t1_en0");
        check_eq("t1_no_grant_en0", 32'(valid_o), 32'd0);
        en_i = 1'b1; req_i = 8'h00; tick("t1_req0");
        check_eq("t1_no_grant_req0", 32'(valid_o), 32'd0);
        done_i = 1'b1; tick("t1_done_idle");
        done_i = 1'b0;

        // 2: scan from ptr 0, then rotate past the released winner
        do_reset();
        en_i = 1'b1; req_i = 8'b1000_0010; tick("t2_g1");
        check_eq("t2_idx1", 32'(grant_idx_o), 32'd1);
        check_eq("t2_grant02", 32'(grant_o), 32'h02);
        done_i = 1'b1; tick("t2_rel");
        check_eq("t2_gap", 32'(valid_o), 32'd0);
        done_i = 1'b0; tick("t2_g7");
        check_eq("t2_idx7", 32'(grant_idx_o), 32'd7);
        check_eq("t2_grant80", 32'(grant_o), 32'h80);

        // 3: all requesting, sequence wraps 7 -> 0 with one idle cycle between grants
        do_reset();
        en_i = 1'b1; req_i = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            tick("t3_grant");
            check_eq("t3_seq_idx", 32'(grant_idx_o), 32'(g % 8));
            done_i = 1'b1; tick("t3_rel");
            check_eq("t3_idle", 32'(valid_o), 32'd0);
            done_i = 1'b0;
        end

        // 4: hold timeout
        do_reset();
        en_i = 1'b1; req_i = 8'h08; tick("t4_grant");
        n = 0;
        while (valid_o && n < 10) begin
            n++;
            tick("t4_hold");
        end
        check_eq("t4_valid_cycles", 32'(n), 32'(TO));
        check_eq("t4_timeout_pulse", 32'(timeout_o), 32'd1);
        tick("t4_regrant");
        check_eq("t4_timeout_gone", 32'(timeout_o), 32'd0);
        check_eq("t4_regrant_idx3", 32'(grant_idx_o), 32'd3);

        // 5: en low keeps the current grant but blocks the next
        do_reset();
        en_i = 1'b1; req_i = 8'h04; tick("t5_grant");
        check_eq("t5_idx2", 32'(grant_idx_o), 32'd2);
        en_i = 1'b0; req_i = 8'hFF; tick("t5_en0_hold");
        check_eq("t5_still_valid", 32'(valid_o), 32'd1);
        done_i = 1'b1; tick("t5_rel");
        done_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("t5_blocked");
            check_eq("t5_no_grant", 32'(valid_o), 32'd0);
        end
        en_i = 1'b1; tick("t5_resume");
        check_eq("t5_idx3", 32'(grant_idx_o), 32'd3);

        // 6: asynchronous reset mid-grant, then ptr back at 0
        do_reset();
        en_i = 1'b1; req_i = 8'h20; tick("t6_grant");
        check_eq("t6_idx5", 32'(grant_idx_o), 32'd5);
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all("t6_async");
        check_eq("t6_grant_zero", 32'(grant_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1; req_i = 8'h21; tick("t6_after");
        check_eq("t6_idx0", 32'(grant_idx_o), 32'd0);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            en_i   = ($urandom_range(3, 0) != 0);
            done_i = ($urandom_range(5, 0) == 0);
            if ($urandom_range(3, 0) == 0) begin
                req_i = 8'($urandom) & 8'($urandom);
            end
            if ($urandom_range(400, 0) == 0) begin
                do_reset();
            end else begin
                tick("rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
